// File: rtl/io_timer.sv
// 8-bit prescaled timer on a 6-register bus window; read data is registered (1 cycle), writes act at the strobe edge.
// Top, match0 and match1 events latch sticky flags; pwm0/pwm1 compare outputs trail CNT by one cycle.
module io_timer #(
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic        top_flag,
  output logic        match0_flag,
  output logic        match1_flag,
  input  logic        top_flag_clr,
  input  logic        match0_flag_clr,
  input  logic        match1_flag_clr,
  output logic        pwm0,
  output logic        pwm1
);

  logic [4:0] r_ctrl;
  logic [7:0] r_cnt;
  logic [7:0] r_top;
  logic [7:0] r_match0;
  logic [7:0] r_match1;
  logic [9:0] r_psc;
  logic       r_top_flag;
  logic       r_match0_flag;
  logic       r_match1_flag;
  logic       r_pwm0;
  logic       r_pwm1;
  logic [7:0] r_dout;

  logic [15:0] w_off;
  logic        w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_ctrl;
  logic        w_wr_cnt;
  logic        w_wr_flags;
  logic        w_en_cnt;
  logic [9:0]  w_div_m1;
  logic        w_tick;
  logic        w_evt;
  logic [7:0]  w_top_eff;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_rdata;
  logic        w_set_top;
  logic        w_set_m0;
  logic        w_set_m1;
  logic        w_clr_top;
  logic        w_clr_m0;
  logic        w_clr_m1;

  // Subtracting the base lets one unsigned compare cover both window edges.
  assign w_off      = address - BASE_ADDR;
  assign w_sel      = (w_off < 16'd6);
  assign w_wr       = w_en & w_sel;
  assign w_rd       = r_en & w_sel;
  assign w_wr_ctrl  = w_wr & (w_off[2:0] == 3'd0);
  assign w_wr_cnt   = w_wr & (w_off[2:0] == 3'd1);
  assign w_wr_flags = w_wr & (w_off[2:0] == 3'd5);

  assign w_en_cnt  = r_ctrl[0];
  assign w_top_eff = r_ctrl[4] ? r_match0 : r_top;

  always_comb begin
    w_div_m1 = 10'd0;
    case (r_ctrl[3:1])
      3'd0:    w_div_m1 = 10'd0;
      3'd1:    w_div_m1 = 10'd1;
      3'd2:    w_div_m1 = 10'd3;
      3'd3:    w_div_m1 = 10'd7;
      3'd4:    w_div_m1 = 10'd15;
      3'd5:    w_div_m1 = 10'd63;
      3'd6:    w_div_m1 = 10'd255;
      default: w_div_m1 = 10'd1023;
    endcase
  end

  assign w_tick = w_en_cnt & (r_psc == w_div_m1);
  // A CNT write on a tick edge suppresses that tick's flag evaluation.
  assign w_evt  = w_tick & ~w_wr_cnt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_tick) begin
      w_cnt_nxt = (r_cnt == w_top_eff) ? 8'h00 : r_cnt + 8'd1;
    end
  end

  assign w_set_top = w_evt & (r_cnt == w_top_eff);
  assign w_set_m0  = w_evt & (r_cnt == r_match0);
  assign w_set_m1  = w_evt & (r_cnt == r_match1);
  assign w_clr_top = top_flag_clr    | (w_wr_flags & din[2]);
  assign w_clr_m0  = match0_flag_clr | (w_wr_flags & din[0]);
  assign w_clr_m1  = match1_flag_clr | (w_wr_flags & din[1]);

  always_comb begin
    w_rdata = 8'h00;
    case (w_off[2:0])
      3'd0:    w_rdata = {3'b000, r_ctrl};
      3'd1:    w_rdata = r_cnt;
      3'd2:    w_rdata = r_top;
      3'd3:    w_rdata = r_match0;
      3'd4:    w_rdata = r_match1;
      3'd5:    w_rdata = {5'b00000, r_top_flag, r_match1_flag, r_match0_flag};
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl        <= 5'd0;
      r_cnt         <= 8'h00;
      r_top         <= 8'hFF;
      r_match0      <= 8'h00;
      r_match1      <= 8'h00;
      r_psc         <= 10'd0;
      r_top_flag    <= 1'b0;
      r_match0_flag <= 1'b0;
      r_match1_flag <= 1'b0;
      r_pwm0        <= 1'b0;
      r_pwm1        <= 1'b0;
      r_dout        <= 8'h00;
    end else begin
      r_dout <= w_rd ? w_rdata : 8'h00;

      if (w_wr_ctrl || !w_en_cnt || w_tick) r_psc <= 10'd0;
      else                                  r_psc <= r_psc + 10'd1;

      if (w_wr_cnt) r_cnt <= din;
      else          r_cnt <= w_cnt_nxt;

      if (w_wr_ctrl)                        r_ctrl   <= din[4:0];
      if (w_wr && (w_off[2:0] == 3'd2))     r_top    <= din;
      if (w_wr && (w_off[2:0] == 3'd3))     r_match0 <= din;
      if (w_wr && (w_off[2:0] == 3'd4))     r_match1 <= din;

      // Set has priority over a coincident clear.
      r_top_flag    <= w_set_top | (r_top_flag    & ~w_clr_top);
      r_match0_flag <= w_set_m0  | (r_match0_flag & ~w_clr_m0);
      r_match1_flag <= w_set_m1  | (r_match1_flag & ~w_clr_m1);

      r_pwm0 <= w_en_cnt & (r_cnt < r_match0);
      r_pwm1 <= w_en_cnt & (r_cnt < r_match1);
    end
  end

  assign dout        = r_dout;
  assign top_flag    = r_top_flag;
  assign match0_flag = r_match0_flag;
  assign match1_flag = r_match1_flag;
  assign pwm0        = r_pwm0;
  assign pwm1        = r_pwm1;

endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: a cycle-level reference model predicts outputs per edge, a monitor compares them.
module tb_io_timer;

  localparam logic [15:0] BASE = 16'h0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic [7:0]  din;
  logic        w_en, r_en;
  logic [7:0]  dout;
  logic        top_flag, match0_flag, match1_flag;
  logic        top_flag_clr, match0_flag_clr, match1_flag_clr;
  logic        pwm0, pwm1;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .din(din), .w_en(w_en), .r_en(r_en),
    .dout(dout), .top_flag(top_flag), .match0_flag(match0_flag), .match1_flag(match1_flag),
    .top_flag_clr(top_flag_clr), .match0_flag_clr(match0_flag_clr),
    .match1_flag_clr(match1_flag_clr), .pwm0(pwm0), .pwm1(pwm1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic       tf, m0f, m1f, p0, p1;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int divs [0:7] = '{1, 2, 4, 8, 16, 64, 256, 1024};

  logic [4:0] m_ctrl;
  logic [7:0] m_cnt, m_top, m_m0, m_m1;
  logic       m_tf, m_m0f, m_m1f;
  int         m_phase;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 5'd0; m_cnt = 8'h00; m_top = 8'hFF; m_m0 = 8'h00; m_m1 = 8'h00;
    m_tf = 1'b0; m_m0f = 1'b0; m_m1f = 1'b0; m_phase = 0;
  endtask

  // Predicts the register state and outputs after the coming rising edge.
  task automatic model_step();
    int off, div;
    bit sel, wr, rd, en, tick, ev;
    logic [7:0] t_eff, rdv;
    exp_t e;
    off = int'(address) - int'(BASE);
    sel = (off >= 0) && (off < 6);
    wr  = w_en && sel;
    rd  = r_en && sel;
    case (off)
      0:       rdv = {3'b000, m_ctrl};
      1:       rdv = m_cnt;
      2:       rdv = m_top;
      3:       rdv = m_m0;
      4:       rdv = m_m1;
      5:       rdv = {5'b00000, m_tf, m_m1f, m_m0f};
      default: rdv = 8'h00;
    endcase
    e.dout = rd ? rdv : 8'h00;
    en    = m_ctrl[0];
    div   = divs[m_ctrl[3:1]];
    tick  = en && (m_phase == div - 1);
    t_eff = m_ctrl[4] ? m_m0 : m_top;
    ev    = tick && !(wr && off == 1);
    e.tf  = (ev && m_cnt == t_eff) || (m_tf  && !(top_flag_clr    || (wr && off == 5 && din[2])));
    e.m0f = (ev && m_cnt == m_m0)  || (m_m0f && !(match0_flag_clr || (wr && off == 5 && din[0])));
    e.m1f = (ev && m_cnt == m_m1)  || (m_m1f && !(match1_flag_clr || (wr && off == 5 && din[1])));
    e.p0  = en && (m_cnt < m_m0);
    e.p1  = en && (m_cnt < m_m1);
    m_phase = ((wr && off == 0) || !en) ? 0 : (m_phase + 1) % div;
    if (wr && off == 1) m_cnt = din;
    else if (tick)      m_cnt = (m_cnt == t_eff) ? 8'h00 : 8'((int'(m_cnt) + 1) % 256);
    if (wr && off == 0) m_ctrl = din[4:0];
    if (wr && off == 2) m_top  = din;
    if (wr && off == 3) m_m0   = din;
    if (wr && off == 4) m_m1   = din;
    m_tf = e.tf; m_m0f = e.m0f; m_m1f = e.m1f;
    q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input bit we, input bit re,
                       input logic [2:0] clr);
    @(negedge clk);
    address = a; din = d; w_en = we; r_en = re;
    {top_flag_clr, match1_flag_clr, match0_flag_clr} = clr;
    model_step();
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    drive(BASE + 16'(off), d, 1'b1, 1'b0, 3'b000);
  endtask

  task automatic rd(input int off);
    drive(BASE + 16'(off), 8'h00, 1'b0, 1'b1, 3'b000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_flags"}, {top_flag, match1_flag, match0_flag}, 0);
    chk({tag, "_pwm"}, {pwm1, pwm0}, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout", dout, e.dout);
        chk("top_flag", top_flag, e.tf);
        chk("match0_flag", match0_flag, e.m0f);
        chk("match1_flag", match1_flag, e.m1f);
        chk("pwm0", pwm0, e.p0);
        chk("pwm1", pwm1, e.p1);
      end
    end
  end

  initial begin : stim
    int guard;
    rst_n = 1'b0; address = 16'h0; din = 8'h0; w_en = 1'b0; r_en = 1'b0;
    top_flag_clr = 1'b0; match0_flag_clr = 1'b0; match1_flag_clr = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    rd(2);
    rd(0);

    // TOP=3 free-running count with a top event every 4 ticks
    wr(2, 8'h03);
    wr(0, 8'h01);
    for (int i = 0; i < 10; i++) rd(1);

    // Prescaler /8 with MATCH1=2
    wr(0, 8'h00);
    wr(5, 8'hFF);
    wr(2, 8'hFF);
    wr(1, 8'h00);
    wr(4, 8'h02);
    wr(0, 8'h07);
    for (int i = 0; i < 40; i++) rd(i % 2 == 0 ? 1 : 5);

    // Coincident set and clear of top_flag, then a lone clear
    wr(0, 8'h00);
    wr(1, 8'h00);
    wr(2, 8'h03);
    wr(0, 8'h01);
    guard = 0;
    while (!(m_cnt == 8'h02 && m_tf) && guard < 20) begin rd(5); guard++; end
    chk("clr_setup_reached", guard < 20, 1);
    rd(5);
    drive(BASE + 16'd5, 8'h00, 1'b0, 1'b1, 3'b100);
    drive(BASE + 16'd5, 8'h00, 1'b0, 1'b1, 3'b100);
    rd(5);

    // CTC mode with MATCH0=4
    wr(0, 8'h00);
    wr(5, 8'h07);
    wr(1, 8'h00);
    wr(3, 8'h04);
    wr(2, 8'hFF);
    wr(0, 8'h11);
    for (int i = 0; i < 14; i++) rd(1);

    // Out-of-window reads and writes, read-during-write
    rd(6);
    rd(-1);
    drive(BASE + 16'd7, 8'hAA, 1'b1, 1'b1, 3'b000);
    wr(4, 8'h33);
    drive(BASE + 16'd4, 8'h77, 1'b1, 1'b1, 3'b000);
    rd(4);

    // Asynchronous reset in the middle of a count
    wr(0, 8'h00);
    wr(2, 8'hFF);
    wr(3, 8'h80);
    wr(1, 8'h50);
    wr(0, 8'h01);
    guard = 0;
    while (m_cnt != 8'h55 && guard < 20) begin rd(1); guard++; end
    chk("cnt55_reached", guard < 20, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    address = 16'h0; w_en = 1'b0; r_en = 1'b0;
    top_flag_clr = 1'b0; match0_flag_clr = 1'b0; match1_flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rd(1);
    rd(2);
    rd(0);

    // Randomized traffic around the register window
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic [2:0]  c;
      bit          we, re;
      a  = BASE - 16'd2 + 16'($urandom_range(0, 10));
      d  = 8'($urandom);
      if (a == BASE) d[3] = 1'b0;
      we = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      drive(a, d, we, re, c);
    end

    drive(16'h0000, 8'h00, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
